// File: rtl/scrambler_seq_if.sv
// Byte-in / bit-out stream interface of the 802.11 transmit scrambler sequencer.
// The slave side is the sequencer; the master side feeds bytes and sinks bits.
interface scrambler_seq_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       out_bit;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic [1:0] phase;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_bit,
    input  out_valid,
    output out_ready,
    input  out_last,
    input  phase
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_bit,
    output out_valid,
    input  out_ready,
    output out_last,
    output phase
  );
endinterface

// File: rtl/scrambler_seq.sv
// Frame-level 802.11 OFDM transmit scrambler: sequences SERVICE, PSDU, TAIL and PAD bits
// through an x^7+x^4+1 scrambler and emits one bit per handshake.
module scrambler_seq #(
  parameter int unsigned LEN_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [6:0]       seed,
  input  logic [LEN_W-1:0] psdu_len,
  input  logic [7:0]       n_dbps,
  scrambler_seq_if.slave   bus,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {StIdle, StService, StData, StTail, StPad} state_e;

  state_e           state_q, state_d;
  logic [6:0]       lfsr_q, lfsr_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       sc_q, sc_d;
  logic [7:0]       n_dbps_q, n_dbps_d;
  logic [LEN_W-1:0] bytes_left_q, bytes_left_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [2:0]       idx_q, idx_d;
  logic             done_q, done_d;

  logic fb;
  logic xfer;
  logic accept;
  logic sc_wrap;
  logic in_ready;
  logic out_valid;

  assign fb      = lfsr_q[6] ^ lfsr_q[3];
  assign xfer    = out_valid && bus.out_ready;
  assign accept  = bus.in_valid && in_ready;
  // Symbol counter reaches n_dbps on this transfer, i.e. an OFDM symbol boundary.
  assign sc_wrap = (sc_q + 8'd1) == n_dbps_q;

  assign busy          = (state_q != StIdle);
  assign done          = done_q;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;

  // Output decode: bit source, phase, handshakes and end-of-frame flag.
  always_comb begin
    out_valid    = 1'b0;
    in_ready     = 1'b0;
    bus.out_bit  = 1'b0;
    bus.phase    = 2'd0;
    bus.out_last = 1'b0;
    unique case (state_q)
      StIdle: ;
      StService: begin
        out_valid   = 1'b1;
        bus.out_bit = fb;
        bus.phase   = 2'd0;
      end
      StData: begin
        out_valid   = hold_full_q;
        bus.out_bit = hold_full_q ? (hold_q[idx_q] ^ fb) : 1'b0;
        bus.phase   = 2'd1;
        // Refill in the cycle the last buffered bit leaves so the stream has no bubbles.
        in_ready    = (bytes_left_q != '0) &&
                      (!hold_full_q || (hold_full_q && bus.out_ready && idx_q == 3'd7));
      end
      StTail: begin
        out_valid    = 1'b1;
        bus.out_bit  = 1'b0;
        bus.phase    = 2'd2;
        bus.out_last = (bit_cnt_q == 4'd5) && sc_wrap;
      end
      StPad: begin
        out_valid    = 1'b1;
        bus.out_bit  = fb;
        bus.phase    = 2'd3;
        bus.out_last = sc_wrap;
      end
      default: ;
    endcase
  end

  // Next-state: frame sequencing, scrambler advance, byte buffering and counters.
  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    bit_cnt_d    = bit_cnt_q;
    sc_d         = sc_q;
    n_dbps_d     = n_dbps_q;
    bytes_left_d = bytes_left_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    idx_d        = idx_q;
    done_d       = 1'b0;

    // Scrambler and symbol counter advance on every transfer, TAIL included.
    if (xfer) begin
      lfsr_d = {lfsr_q[5:0], fb};
      sc_d   = sc_wrap ? 8'd0 : sc_q + 8'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d      = StService;
          // An all-zero seed would lock the scrambler up.
          lfsr_d       = (seed == 7'd0) ? 7'h7F : seed;
          bytes_left_d = psdu_len;
          n_dbps_d     = n_dbps;
          bit_cnt_d    = 4'd0;
          sc_d         = 8'd0;
          hold_full_d  = 1'b0;
          idx_d        = 3'd0;
        end
      end
      StService: begin
        if (xfer) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd15) begin
            bit_cnt_d = 4'd0;
            state_d   = (bytes_left_q != '0) ? StData : StTail;
          end
        end
      end
      StData: begin
        if (accept) begin
          hold_d       = bus.in_data;
          hold_full_d  = 1'b1;
          idx_d        = 3'd0;
          bytes_left_d = bytes_left_q - LEN_W'(1);
        end else if (xfer && idx_q == 3'd7) begin
          hold_full_d = 1'b0;
          idx_d       = 3'd0;
          if (bytes_left_q == '0) begin
            state_d = StTail;
          end
        end else if (xfer) begin
          idx_d = idx_q + 3'd1;
        end
      end
      StTail: begin
        if (xfer) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd5) begin
            bit_cnt_d = 4'd0;
            state_d   = sc_wrap ? StIdle : StPad;
            done_d    = sc_wrap;
          end
        end
      end
      StPad: begin
        if (xfer && sc_wrap) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      lfsr_q       <= 7'h7F;
      bit_cnt_q    <= 4'd0;
      sc_q         <= 8'd0;
      n_dbps_q     <= 8'd0;
      bytes_left_q <= '0;
      hold_q       <= 8'd0;
      hold_full_q  <= 1'b0;
      idx_q        <= 3'd0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      bit_cnt_q    <= bit_cnt_d;
      sc_q         <= sc_d;
      n_dbps_q     <= n_dbps_d;
      bytes_left_q <= bytes_left_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      idx_q        <= idx_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_scrambler_seq.sv
// Scoreboard bench for scrambler_seq: a frame model pushes expected bits, the output
// monitor pops and compares them on every transfer.
module tb_scrambler_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  seed;
  logic [11:0] psdu_len;
  logic [7:0]  n_dbps;
  logic        busy;
  logic        done;

  scrambler_seq_if bus ();

  scrambler_seq #(.LEN_W(12)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .seed     (seed),
    .psdu_len (psdu_len),
    .n_dbps   (n_dbps),
    .bus      (bus),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] tx_bytes[$];
  logic [3:0] exp_q[$];   // {last, phase, bit}
  logic       obs_q[$];
  logic       ref_q[$];

  // Reference frame built straight from the frame-length formula and the LFSR recurrence.
  task automatic model_frame(input logic [6:0] s0, input int len, input int n);
    int total;
    logic [6:0] s;
    total = ((22 + 8 * len + n - 1) / n) * n;
    s = (s0 == 7'd0) ? 7'h7F : s0;
    exp_q.delete();
    for (int i = 0; i < total; i++) begin
      logic [1:0] ph;
      logic       fb;
      logic       src;
      logic       b;
      logic [7:0] by;
      int         d;
      d = i - 16;
      if (i < 16) ph = 2'd0;
      else if (i < 16 + 8 * len) ph = 2'd1;
      else if (i < 22 + 8 * len) ph = 2'd2;
      else ph = 2'd3;
      fb  = s[6] ^ s[3];
      src = 1'b0;
      if (ph == 2'd1) begin
        by  = tx_bytes[d / 8];
        src = by[d % 8];
      end
      b = (ph == 2'd2) ? 1'b0 : (src ^ fb);
      s = {s[5:0], fb};
      exp_q.push_back({(i == total - 1), ph, b});
    end
  endtask

  task automatic fill_random(input int len);
    tx_bytes.delete();
    for (int i = 0; i < len; i++) tx_bytes.push_back(8'($urandom));
  endtask

  // Drives one frame, optionally with random stalls and a stray start, and scoreboards it.
  task automatic run_frame(input logic [6:0] f_seed, input int f_len, input logic [7:0] f_n,
                           input bit f_stall, input bit f_poke);
    int         byte_idx;
    int         cyc;
    int         budget;
    bit         fin;
    bit         pstall;
    logic       pb;
    logic       pl;
    logic [1:0] pp;
    logic [3:0] e;
    byte_idx = 0;
    cyc      = 0;
    fin      = 1'b0;
    pstall   = 1'b0;
    pb       = 1'b0;
    pl       = 1'b0;
    pp       = 2'd0;
    obs_q.delete();
    model_frame(f_seed, f_len, int'(f_n));
    budget = exp_q.size() * 4 + 64;

    @(negedge clk);
    start    = 1'b1;
    seed     = f_seed;
    psdu_len = 12'(f_len);
    n_dbps   = f_n;
    @(negedge clk);
    start    = 1'b0;
    seed     = 7'h2A;
    psdu_len = 12'd7;
    n_dbps   = 8'd40;
    #1;
    n_vec++;
    if (busy !== 1'b1 || bus.out_valid !== 1'b1 || bus.phase !== 2'd0) begin
      n_err++;
      $display("FAIL start_resp: got busy=%b valid=%b phase=%0d want 1 1 0",
               busy, bus.out_valid, bus.phase);
    end

    while (!fin && cyc < budget) begin
      start         = f_poke && (cyc == 5 || cyc == 40);
      seed          = 7'h15;
      bus.out_ready = f_stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.in_valid  = (byte_idx < f_len) && (f_stall ? ($urandom_range(0, 1) != 0) : 1'b1);
      bus.in_data   = (byte_idx < f_len) ? tx_bytes[byte_idx] : 8'($urandom);
      #1;
      if (bus.in_valid && bus.in_ready) byte_idx++;
      if (pstall) begin
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.out_bit !== pb || bus.phase !== pp ||
            bus.out_last !== pl) begin
          n_err++;
          $display("FAIL stall_hold: got v=%b b=%b ph=%0d l=%b want 1 %b %0d %b",
                   bus.out_valid, bus.out_bit, bus.phase, bus.out_last, pb, pp, pl);
        end
      end
      pstall = bus.out_valid && !bus.out_ready;
      pb     = bus.out_bit;
      pp     = bus.phase;
      pl     = bus.out_last;
      if (bus.out_valid && bus.out_ready) begin
        obs_q.push_back(bus.out_bit);
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL extra_bit: got bit %0d want end of frame", obs_q.size() - 1);
          fin = 1'b1;
        end else begin
          e = exp_q.pop_front();
          if ({bus.out_last, bus.phase, bus.out_bit} !== e) begin
            n_err++;
            $display("FAIL bit[%0d]: got last=%b ph=%0d b=%b want last=%b ph=%0d b=%b",
                     obs_q.size() - 1, bus.out_last, bus.phase, bus.out_bit, e[3], e[2:1], e[0]);
          end
        end
        if (bus.out_last === 1'b1) fin = 1'b1;
      end
      cyc++;
      @(negedge clk);
    end
    start        = 1'b0;
    bus.in_valid = 1'b0;

    n_vec++;
    if (!fin) begin
      n_err++;
      $display("FAIL timeout: got %0d bits after %0d cycles want frame end", obs_q.size(), cyc);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL bit_count: got %0d bits want %0d", obs_q.size(), obs_q.size() + exp_q.size());
    end
    #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL done_pulse: got busy=%b done=%b valid=%b want 0 1 0",
               busy, done, bus.out_valid);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL done_clear: got %b want 0", done);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_bit !== 1'b0 ||
        bus.out_last !== 1'b0 || bus.phase !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got rdy=%b v=%b b=%b l=%b ph=%0d busy=%b done=%b want all 0",
               bus.in_ready, bus.out_valid, bus.out_bit, bus.out_last, bus.phase, busy, done);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_empty_frame;
    logic [15:0] svc;
    svc = 16'b0000111011110010;
    tx_bytes.delete();
    run_frame(7'h7F, 0, 8'd24, 1'b0, 1'b0);
    n_vec++;
    if (obs_q.size() != 24) begin
      n_err++;
      $display("FAIL empty_len: got %0d want 24", obs_q.size());
    end
    for (int i = 0; i < 16 && i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== svc[15 - i]) begin
        n_err++;
        $display("FAIL service[%0d]: got %b want %b", i, obs_q[i], svc[15 - i]);
      end
    end
  endtask

  task automatic test_zero_byte;
    logic [29:0] seq;
    seq = 30'b000011101111001011001001000000;
    tx_bytes.delete();
    tx_bytes.push_back(8'h00);
    run_frame(7'h7F, 1, 8'd24, 1'b0, 1'b0);
    n_vec++;
    if (obs_q.size() != 48) begin
      n_err++;
      $display("FAIL zero_len: got %0d want 48", obs_q.size());
    end
    for (int i = 0; i < 30 && i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== seq[29 - i]) begin
        n_err++;
        $display("FAIL lfsr_seq[%0d]: got %b want %b", i, obs_q[i], seq[29 - i]);
      end
    end
  endtask

  // 16 + 16 + 6 = 38 bits is two whole 19-bit symbols, so the frame ends in TAIL.
  task automatic test_exact_fit;
    tx_bytes.delete();
    tx_bytes.push_back(8'hA5);
    tx_bytes.push_back(8'h3C);
    run_frame(7'h7F, 2, 8'd19, 1'b0, 1'b0);
    n_vec++;
    if (obs_q.size() != 38) begin
      n_err++;
      $display("FAIL exact_len: got %0d want 38", obs_q.size());
    end
  endtask

  task automatic test_stalls;
    fill_random(100);
    run_frame(7'h4B, 100, 8'd216, 1'b0, 1'b0);
    ref_q = obs_q;
    n_vec++;
    if (ref_q.size() != 864) begin
      n_err++;
      $display("FAIL long_len: got %0d want 864", ref_q.size());
    end
    run_frame(7'h4B, 100, 8'd216, 1'b1, 1'b0);
    n_vec++;
    if (obs_q != ref_q) begin
      n_err++;
      $display("FAIL stall_stream: got %0d bits differing from %0d-bit unstalled run",
               obs_q.size(), ref_q.size());
    end
  endtask

  task automatic test_seed_zero;
    fill_random(3);
    run_frame(7'h7F, 3, 8'd48, 1'b0, 1'b0);
    ref_q = obs_q;
    run_frame(7'h00, 3, 8'd48, 1'b0, 1'b1);
    n_vec++;
    if (obs_q != ref_q) begin
      n_err++;
      $display("FAIL seed_zero: got %0d bits not matching %0d-bit seed 7F run",
               obs_q.size(), ref_q.size());
    end
  endtask

  task automatic test_back_to_back;
    fill_random(5);
    run_frame(7'h33, 5, 8'd36, 1'b0, 1'b0);
    fill_random(2);
    run_frame(7'h01, 2, 8'd8, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_frame;
    bit hit;
    hit = 1'b0;
    fill_random(4);
    @(negedge clk);
    start    = 1'b1;
    seed     = 7'h5A;
    psdu_len = 12'd4;
    n_dbps   = 8'd48;
    @(negedge clk);
    start         = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h55;
    for (int i = 0; i < 60 && !hit; i++) begin
      #1;
      if (bus.out_valid && bus.phase == 2'd1) hit = 1'b1;
      else @(negedge clk);
    end
    n_vec++;
    if (!hit) begin
      n_err++;
      $display("FAIL reach_data: got no DATA phase want DATA within 60 cycles");
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: got busy=%b v=%b rdy=%b done=%b want 0 0 0 0",
               busy, bus.out_valid, bus.in_ready, done);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      n_vec++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL no_done: got done=%b busy=%b want 0 0", done, busy);
      end
    end
    run_frame(7'h5A, 4, 8'd48, 1'b0, 1'b0);
  endtask

  initial begin
    start         = 1'b0;
    seed          = 7'h00;
    psdu_len      = 12'd0;
    n_dbps        = 8'd24;
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    test_reset;
    test_empty_frame;
    test_zero_byte;
    test_exact_fit;
    test_stalls;
    test_seed_zero;
    test_back_to_back;
    test_reset_mid_frame;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
